// File: rtl/video_pkg.sv
// Shared types and helpers for the raster timing engine.
package video_pkg;

    // One axis of raster timing: active, front porch, sync width, back porch.
    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } timing_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } vte_state_t;

    function automatic int unsigned timing_total(timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

    function automatic logic timing_valid(timing_t t);
        return (t.active != 0) && (t.fp != 0) && (t.sync != 0) && (t.bp != 0);
    endfunction

    // Counter width for an axis of 'total' positions; never narrower than 1 bit.
    function automatic int unsigned count_width(int unsigned total);
        return (total < 2) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/vte_delay_line.sv
// Fixed-length register pipeline with asynchronous reset to a chosen value.
// STAGES=0 degenerates to a plain wire.
module vte_delay_line #(
    parameter int unsigned      WIDTH     = 4,
    parameter int unsigned      STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (STAGES == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign q = d;
    end else begin : g_pipe
        logic [WIDTH-1:0] pipe [STAGES];

        // Shift the bundle one stage per clock; reset loads the inactive pattern.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned i = 0; i < STAGES; i++) pipe[i] <= RESET_VAL;
            end else begin
                pipe[0] <= d;
                for (int unsigned i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
            end
        end

        assign q = pipe[STAGES-1];
    end

endmodule

// File: rtl/video_timing_engine.sv
// Raster timing generator: stage-0 counters and fb coordinates, sync/active/new-frame
// outputs delayed to line up with returned pixel data, run/stop at frame boundaries.
module video_timing_engine
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE      = 1280,
    parameter int unsigned H_FP          = 110,
    parameter int unsigned H_SYNC        = 40,
    parameter int unsigned H_BP          = 220,
    parameter int unsigned V_ACTIVE      = 720,
    parameter int unsigned V_FP          = 5,
    parameter int unsigned V_SYNC        = 5,
    parameter int unsigned V_BP          = 20,
    parameter bit          HS_POL        = 1'b1,
    parameter bit          VS_POL        = 1'b1,
    parameter int unsigned FETCH_LATENCY = 2,
    parameter int unsigned SCALE_SHIFT   = 0,
    parameter int unsigned FC_WIDTH      = 6,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW      = video_pkg::count_width(H_TOTAL),
    localparam int unsigned VW      = video_pkg::count_width(V_TOTAL)
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                en_in,
    output logic [HW-1:0]       hcount_out,
    output logic [VW-1:0]       vcount_out,
    output logic [HW-1:0]       fb_x_out,
    output logic [VW-1:0]       fb_y_out,
    output logic                fetch_out,
    output logic                hs_out,
    output logic                vs_out,
    output logic                ad_out,
    output logic                nf_out,
    output logic [FC_WIDTH-1:0] fc_out,
    output logic                running_out
);

    localparam timing_t H_TIM = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
    localparam timing_t V_TIM = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};

    if (!timing_valid(H_TIM) || !timing_valid(V_TIM) || FETCH_LATENCY > 8) begin : g_param_check
        $error("video_timing_engine: timing parameters must be nonzero and FETCH_LATENCY <= 8");
    end

    localparam logic [HW-1:0] H_LAST = HW'(timing_total(H_TIM) - 1);
    localparam logic [VW-1:0] V_LAST = VW'(timing_total(V_TIM) - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_TIM.active);
    localparam logic [VW-1:0] V_ACT  = VW'(V_TIM.active);
    localparam logic [HW-1:0] HS_BEG = HW'(H_TIM.active + H_TIM.fp);
    localparam logic [HW-1:0] HS_END = HW'(H_TIM.active + H_TIM.fp + H_TIM.sync);
    localparam logic [VW-1:0] VS_BEG = VW'(V_TIM.active + V_TIM.fp);
    localparam logic [VW-1:0] VS_END = VW'(V_TIM.active + V_TIM.fp + V_TIM.sync);

    vte_state_t          state, state_next;
    logic [HW-1:0]       h, h_next, h_adv;
    logic [VW-1:0]       v, v_next, v_adv;
    logic [FC_WIDTH-1:0] fc;
    logic                h_last, frame_end;
    logic                running, fetch0, hs0, vs0, nf0;
    logic [3:0]          delayed;

    assign h_last    = (h == H_LAST);
    assign frame_end = h_last && (v == V_LAST);
    assign h_adv     = h_last ? '0 : h + 1'b1;
    assign v_adv     = !h_last ? v : ((v == V_LAST) ? '0 : v + 1'b1);

    // State, raster position and frame counter registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
            h     <= '0;
            v     <= '0;
            fc    <= '0;
        end else begin
            state <= state_next;
            h     <= h_next;
            v     <= v_next;
            if (nf0) fc <= fc + 1'b1;
        end
    end

    // Run/stop control: a stop request only takes effect once the current frame ends.
    always_comb begin
        state_next = state;
        h_next     = h;
        v_next     = v;
        case (state)
            IDLE: begin
                h_next = '0;
                v_next = '0;
                if (en_in) state_next = RUN;
            end
            RUN: begin
                h_next = h_adv;
                v_next = v_adv;
                if (!en_in) state_next = DRAIN;
            end
            DRAIN: begin
                h_next = h_adv;
                v_next = v_adv;
                if (en_in)          state_next = RUN;
                else if (frame_end) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                h_next     = '0;
                v_next     = '0;
            end
        endcase
    end

    // Stage-0 region decode; everything reads inactive while idle.
    always_comb begin
        running = (state != IDLE);
        fetch0  = running && (h < H_ACT) && (v < V_ACT);
        hs0     = (running && (h >= HS_BEG) && (h < HS_END)) ? HS_POL : ~HS_POL;
        vs0     = (running && (v >= VS_BEG) && (v < VS_END)) ? VS_POL : ~VS_POL;
        nf0     = running && (h == H_ACT) && (v == V_ACT);
    end

    vte_delay_line #(
        .WIDTH     (4),
        .STAGES    (FETCH_LATENCY),
        .RESET_VAL ({1'b0, 1'b0, ~VS_POL, ~HS_POL})
    ) u_delay (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .d     ({nf0, fetch0, vs0, hs0}),
        .q     (delayed)
    );

    assign hcount_out  = h;
    assign vcount_out  = v;
    assign fb_x_out    = h >> SCALE_SHIFT;
    assign fb_y_out    = v >> SCALE_SHIFT;
    assign fetch_out   = fetch0;
    assign fc_out      = fc;
    assign running_out = running;
    assign {nf_out, ad_out, vs_out, hs_out} = delayed;

endmodule

// File: tb/tb_video_timing_engine.sv
// Bench for video_timing_engine: directed table, hand-written corner sequences,
// and randomized run/stop traffic checked against a linear-pixel-index model.
module tb_video_timing_engine;

    typedef struct packed {
        int unsigned ha, hf, hsw, hb;
        int unsigned va, vf, vsw, vb;
        int unsigned lat, shift, fcw;
        bit          hpol, vpol;
    } cfg_t;

    localparam cfg_t C0 = '{ha: 8, hf: 2, hsw: 2, hb: 2, va: 4, vf: 1, vsw: 1, vb: 1,
                            lat: 2, shift: 0, fcw: 6, hpol: 1'b1, vpol: 1'b1};
    localparam cfg_t C1 = '{ha: 8, hf: 2, hsw: 2, hb: 2, va: 4, vf: 1, vsw: 1, vb: 1,
                            lat: 0, shift: 1, fcw: 2, hpol: 1'b0, vpol: 1'b1};

    localparam int unsigned HW = $clog2(C0.ha + C0.hf + C0.hsw + C0.hb);
    localparam int unsigned VW = $clog2(C0.va + C0.vf + C0.vsw + C0.vb);

    localparam int unsigned M_IDLE  = 0;
    localparam int unsigned M_RUN   = 1;
    localparam int unsigned M_DRAIN = 2;

    // Model state: mode, linear pixel index within the frame, frame count, and a
    // history of stage-0 {nf,fetch,vs,hs} bundles, newest in bits [3:0].
    typedef struct packed {
        int unsigned mode;
        int unsigned p;
        int unsigned fc;
        logic [35:0] hist;
    } mst_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en0 = 1'b0;
    logic en1 = 1'b0;

    logic [HW-1:0] h0, fbx0, h1, fbx1;
    logic [VW-1:0] v0, fby0, v1, fby1;
    logic          fetch0, hs0, vs0, ad0, nf0, run0;
    logic          fetch1, hs1, vs1, ad1, nf1, run1;
    logic [5:0]    fc0;
    logic [1:0]    fc1;

    int   tests = 0;
    int   fails = 0;
    mst_t m0, m1;

    always #5 clk = ~clk;

    video_timing_engine #(
        .H_ACTIVE(C0.ha), .H_FP(C0.hf), .H_SYNC(C0.hsw), .H_BP(C0.hb),
        .V_ACTIVE(C0.va), .V_FP(C0.vf), .V_SYNC(C0.vsw), .V_BP(C0.vb),
        .HS_POL(C0.hpol), .VS_POL(C0.vpol), .FETCH_LATENCY(C0.lat),
        .SCALE_SHIFT(C0.shift), .FC_WIDTH(C0.fcw)
    ) dut0 (
        .clk_in(clk), .rst_n_in(rst_n), .en_in(en0),
        .hcount_out(h0), .vcount_out(v0), .fb_x_out(fbx0), .fb_y_out(fby0),
        .fetch_out(fetch0), .hs_out(hs0), .vs_out(vs0), .ad_out(ad0), .nf_out(nf0),
        .fc_out(fc0), .running_out(run0)
    );

    video_timing_engine #(
        .H_ACTIVE(C1.ha), .H_FP(C1.hf), .H_SYNC(C1.hsw), .H_BP(C1.hb),
        .V_ACTIVE(C1.va), .V_FP(C1.vf), .V_SYNC(C1.vsw), .V_BP(C1.vb),
        .HS_POL(C1.hpol), .VS_POL(C1.vpol), .FETCH_LATENCY(C1.lat),
        .SCALE_SHIFT(C1.shift), .FC_WIDTH(C1.fcw)
    ) dut1 (
        .clk_in(clk), .rst_n_in(rst_n), .en_in(en1),
        .hcount_out(h1), .vcount_out(v1), .fb_x_out(fbx1), .fb_y_out(fby1),
        .fetch_out(fetch1), .hs_out(hs1), .vs_out(vs1), .ad_out(ad1), .nf_out(nf1),
        .fc_out(fc1), .running_out(run1)
    );

    function automatic logic [3:0] stage0(cfg_t c, mst_t s);
        int unsigned ht, h, v;
        logic run, f, hsv, vsv, nfv;
        ht  = c.ha + c.hf + c.hsw + c.hb;
        h   = s.p % ht;
        v   = s.p / ht;
        run = (s.mode != M_IDLE);
        f   = run && (h < c.ha) && (v < c.va);
        hsv = (run && h >= c.ha + c.hf && h < c.ha + c.hf + c.hsw) ? c.hpol : ~c.hpol;
        vsv = (run && v >= c.va + c.vf && v < c.va + c.vf + c.vsw) ? c.vpol : ~c.vpol;
        nfv = run && (h == c.ha) && (v == c.va);
        return {nfv, f, vsv, hsv};
    endfunction

    function automatic mst_t m_reset(cfg_t c);
        mst_t s;
        logic [3:0] idle_b;
        idle_b = {1'b0, 1'b0, ~c.vpol, ~c.hpol};
        s.mode = M_IDLE;
        s.p    = 0;
        s.fc   = 0;
        s.hist = {9{idle_b}};
        return s;
    endfunction

    function automatic mst_t m_step(cfg_t c, mst_t s, bit e);
        mst_t n;
        int unsigned frame;
        logic [3:0] b;
        n     = s;
        frame = (c.ha + c.hf + c.hsw + c.hb) * (c.va + c.vf + c.vsw + c.vb);
        b     = stage0(c, s);
        if (b[3]) n.fc = (s.fc + 1) % (1 << c.fcw);
        if (s.mode == M_IDLE) begin
            if (e) begin
                n.mode = M_RUN;
                n.p    = 0;
            end
        end else begin
            n.p = (s.p + 1) % frame;
            if (s.mode == M_RUN) begin
                if (!e) n.mode = M_DRAIN;
            end else if (e) begin
                n.mode = M_RUN;
            end else if (s.p == frame - 1) begin
                n.mode = M_IDLE;
            end
        end
        b      = stage0(c, n);
        n.hist = {s.hist[31:0], b};
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input cfg_t c, input mst_t s,
                             input logic [31:0] h, input logic [31:0] v,
                             input logic [31:0] fbx, input logic [31:0] fby,
                             input logic fetch, input logic hs, input logic vs,
                             input logic ad, input logic nf, input logic [31:0] fc,
                             input logic run);
        int unsigned ht, eh, ev;
        logic [3:0] cur, del;
        ht  = c.ha + c.hf + c.hsw + c.hb;
        eh  = s.p % ht;
        ev  = s.p / ht;
        cur = s.hist[3:0];
        del = s.hist[4*c.lat +: 4];
        chk({tag, ".hcount"}, h, eh);
        chk({tag, ".vcount"}, v, ev);
        chk({tag, ".fb_x"}, fbx, eh >> c.shift);
        chk({tag, ".fb_y"}, fby, ev >> c.shift);
        chk({tag, ".fetch"}, {31'd0, fetch}, {31'd0, cur[2]});
        chk({tag, ".hs"}, {31'd0, hs}, {31'd0, del[0]});
        chk({tag, ".vs"}, {31'd0, vs}, {31'd0, del[1]});
        chk({tag, ".ad"}, {31'd0, ad}, {31'd0, del[2]});
        chk({tag, ".nf"}, {31'd0, nf}, {31'd0, del[3]});
        chk({tag, ".fc"}, fc, s.fc);
        chk({tag, ".running"}, {31'd0, run}, {31'd0, (s.mode != M_IDLE)});
    endtask

    task automatic check_both(input string tag);
        check_all({tag, ".d0"}, C0, m0, h0, v0, fbx0, fby0, fetch0, hs0, vs0, ad0, nf0, fc0, run0);
        check_all({tag, ".d1"}, C1, m1, h1, v1, fbx1, fby1, fetch1, hs1, vs1, ad1, nf1, fc1, run1);
    endtask

    // One clock: drive enables at the falling edge, step the models at the rising edge.
    task automatic tick(input bit e0, input bit e1);
        en0 = e0;
        en1 = e1;
        @(posedge clk);
        m0 = m_step(C0, m0, e0);
        m1 = m_step(C1, m1, e1);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en0   = 1'b0;
        en1   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m0 = m_reset(C0);
        m1 = m_reset(C1);
    endtask

    typedef struct {
        bit en;
        int n;
        int h, v;
        bit run, fetch, hs, vs, ad, nf;
        int fc;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [19];
        int   cnt;
        bit   e0, e1;

        //               en  n   h  v  run fet hs vs ad nf fc
        tbl[0]  = '{1'b1,  1,  0, 0, 1, 1, 0, 0, 0, 0, 0};
        tbl[1]  = '{1'b1, 10, 10, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{1'b1,  5,  1, 1, 1, 1, 0, 0, 0, 0, 0};
        tbl[3]  = '{1'b1, 16,  3, 2, 1, 1, 0, 0, 1, 0, 0};
        tbl[4]  = '{1'b0,  1,  4, 2, 1, 1, 0, 0, 1, 0, 0};
        tbl[5]  = '{1'b0,  1,  5, 2, 1, 1, 0, 0, 1, 0, 0};
        tbl[6]  = '{1'b1,  1,  6, 2, 1, 1, 0, 0, 1, 0, 0};
        tbl[7]  = '{1'b0, 63, 13, 6, 1, 0, 1, 0, 0, 0, 1};
        tbl[8]  = '{1'b0,  1,  0, 0, 0, 0, 0, 0, 0, 0, 1};
        tbl[9]  = '{1'b0,  3,  0, 0, 0, 0, 0, 0, 0, 0, 1};
        tbl[10] = '{1'b1,  1,  0, 0, 1, 1, 0, 0, 0, 0, 1};
        tbl[11] = '{1'b1, 64,  8, 4, 1, 0, 0, 0, 0, 0, 1};
        tbl[12] = '{1'b1,  1,  9, 4, 1, 0, 0, 0, 0, 0, 2};
        tbl[13] = '{1'b1,  1, 10, 4, 1, 0, 0, 0, 0, 1, 2};
        tbl[14] = '{1'b1,  1, 11, 4, 1, 0, 0, 0, 0, 0, 2};
        tbl[15] = '{1'b1,  1, 12, 4, 1, 0, 1, 0, 0, 0, 2};
        tbl[16] = '{1'b1,  1, 13, 4, 1, 0, 1, 0, 0, 0, 2};
        tbl[17] = '{1'b1,  1,  0, 5, 1, 0, 0, 0, 0, 0, 2};
        tbl[18] = '{1'b1,  2,  2, 5, 1, 0, 0, 1, 0, 0, 2};

        m0 = m_reset(C0);
        m1 = m_reset(C1);
        @(negedge clk);
        check_both("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table on the latency-2 instance.
        for (int i = 0; i < 19; i++) begin
            repeat (tbl[i].n) tick(tbl[i].en, 1'b0);
            chk($sformatf("row%0d.h", i), h0, tbl[i].h);
            chk($sformatf("row%0d.v", i), v0, tbl[i].v);
            chk($sformatf("row%0d.running", i), {31'd0, run0}, {31'd0, tbl[i].run});
            chk($sformatf("row%0d.fetch", i), {31'd0, fetch0}, {31'd0, tbl[i].fetch});
            chk($sformatf("row%0d.hs", i), {31'd0, hs0}, {31'd0, tbl[i].hs});
            chk($sformatf("row%0d.vs", i), {31'd0, vs0}, {31'd0, tbl[i].vs});
            chk($sformatf("row%0d.ad", i), {31'd0, ad0}, {31'd0, tbl[i].ad});
            chk($sformatf("row%0d.nf", i), {31'd0, nf0}, {31'd0, tbl[i].nf});
            chk($sformatf("row%0d.fc", i), fc0, tbl[i].fc);
        end

        // Frame period measured between consecutive nf_out pulses.
        cnt = 0;
        while (nf0 !== 1'b1 && cnt < 200) begin
            tick(1'b1, 1'b0);
            cnt++;
        end
        chk("nf_seen", {31'd0, nf0}, 32'd1);
        cnt = 0;
        do begin
            tick(1'b1, 1'b0);
            cnt++;
        end while (nf0 !== 1'b1 && cnt < 200);
        chk("frame_cycles", cnt, 98);

        // Asynchronous reset in the middle of an active line.
        cnt = 0;
        while (!(h0 == 4'd4 && v0 == 3'd1) && cnt < 200) begin
            tick(1'b1, 1'b0);
            cnt++;
        end
        chk("reached_4_1", {28'd0, h0}, 32'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.h", h0, 0);
        chk("arst.v", v0, 0);
        chk("arst.fetch", {31'd0, fetch0}, 0);
        chk("arst.hs", {31'd0, hs0}, 0);
        chk("arst.vs", {31'd0, vs0}, 0);
        chk("arst.ad", {31'd0, ad0}, 0);
        chk("arst.nf", {31'd0, nf0}, 0);
        chk("arst.fc", fc0, 0);
        chk("arst.running", {31'd0, run0}, 0);
        chk("arst.hs1_inactive_high", {31'd0, hs1}, 1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m0 = m_reset(C0);
        m1 = m_reset(C1);
        check_both("post_arst");

        // Scaled coordinates, active-low hsync and 2-bit frame counter wrap.
        tick(1'b0, 1'b1);
        chk("scale.fbx0", fbx1, 0);
        for (int i = 1; i < 8; i++) begin
            tick(1'b0, 1'b1);
            chk($sformatf("scale.fbx%0d", i), fbx1, i / 2);
        end
        for (int i = 8; i < 14; i++) begin
            tick(1'b0, 1'b1);
            chk($sformatf("pol.hs_h%0d", i), {31'd0, hs1}, (i >= 10 && i < 12) ? 0 : 1);
        end
        repeat (345) tick(1'b0, 1'b1);
        chk("fcwrap.before", fc1, 3);
        tick(1'b0, 1'b1);
        chk("fcwrap.after", fc1, 0);

        // Randomized run/stop traffic on both instances.
        do_reset();
        check_both("rand_reset");
        e0 = 1'b1;
        e1 = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 39) == 0) e0 = ~e0;
            if ($urandom_range(0, 39) == 0) e1 = ~e1;
            tick(e0, e1);
            check_both("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
